led_activity: RTL and testbench

LED_ACTIVITY -- requirements
Module: led_activity

---
 rtl/led_pkg.sv | 24 ++
 rtl/led_chan.sv | 60 ++++++
 rtl/led_activity.sv | 79 +++++++
 tb/tb_led_activity.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED activity indicator slice:
// display mode encodings and a constant-evaluable ceil(log2) helper.
package led_pkg;

   typedef enum logic [1:0] {
      LED_DIRECT  = 2'b00,
      LED_STRETCH = 2'b01,
      LED_DIM     = 2'b10,
      LED_TEST    = 2'b11
   } led_mode_e;

   // Minimum result of 1 keeps degenerate parameters from making zero-width vectors.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((longint'(1) << i) < longint'(value)) begin
            r = i + 1;
         end
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/led_chan.sv
// One activity channel: input synchroniser, hold (stretch) counter
// and registered output mux selected by display mode.
module led_chan
   import led_pkg::*;
#(
   parameter int HOLD_TICKS = 5000,
   parameter int HOLD_W     = 13
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      act,
   input  logic      tick,
   input  led_mode_e mode,
   input  logic      dim_on,
   output logic      led
);

   logic              act_m;
   logic              act_s;
   logic [HOLD_W-1:0] hold;
   logic              stretched;

   assign stretched = act_s | (hold != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_m <= 1'b0;
         act_s <= 1'b0;
      end else begin
         act_m <= act;
         act_s <= act_m;
      end
   end

   // Reload has priority over the tick-driven decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold <= '0;
      end else if (act_s) begin
         hold <= HOLD_W'(HOLD_TICKS);
      end else if (tick && (hold != '0)) begin
         hold <= hold - HOLD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= 1'b0;
      end else begin
         unique case (mode)
            LED_DIRECT:  led <= act_s;
            LED_STRETCH: led <= stretched;
            LED_DIM:     led <= stretched & dim_on;
            LED_TEST:    led <= 1'b1;
            default:     led <= 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/led_activity.sv
// Per-cog activity LEDs with pulse stretching, PWM dimming and lamp test.
// Shared tick prescaler and PWM counter feed NUMCOGS channel instances.
module led_activity
   import led_pkg::*;
#(
   parameter int NUMCOGS    = 8,
   parameter int PRESCALE   = 16000,
   parameter int HOLD_TICKS = 5000,
   parameter int PWM_W      = 4
) (
   input  logic               clock_160,
   input  logic               inp_resn,
   input  logic [NUMCOGS-1:0] cog_act,
   input  logic [1:0]         mode,
   input  logic [PWM_W-1:0]   duty,
   output logic [NUMCOGS-1:0] ledg
);

   localparam int PS_W   = clog2(PRESCALE);
   localparam int HOLD_W = clog2(HOLD_TICKS + 1);

   logic [1:0]       rst_q;
   logic             rst_n;
   logic [PS_W-1:0]  ps_cnt;
   logic             tick;
   logic [PWM_W-1:0] pwm_cnt;
   logic             dim_on;
   led_mode_e        mode_e;

   // Assert passes straight through; release is retimed by two flops.
   always_ff @(posedge clock_160 or negedge inp_resn) begin
      if (!inp_resn) begin
         rst_q <= 2'b00;
      end else begin
         rst_q <= {rst_q[0], 1'b1};
      end
   end

   assign rst_n = rst_q[1];

   assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

   always_ff @(posedge clock_160 or negedge rst_n) begin
      if (!rst_n) begin
         ps_cnt <= '0;
      end else if (tick) begin
         ps_cnt <= '0;
      end else begin
         ps_cnt <= ps_cnt + PS_W'(1);
      end
   end

   always_ff @(posedge clock_160 or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else if (tick) begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
   end

   assign dim_on = (pwm_cnt < duty);
   assign mode_e = led_mode_e'(mode);

   for (genvar i = 0; i < NUMCOGS; i++) begin : g_chan
      led_chan #(
         .HOLD_TICKS (HOLD_TICKS),
         .HOLD_W     (HOLD_W)
      ) u_chan (
         .clk    (clock_160),
         .rst_n  (rst_n),
         .act    (cog_act[i]),
         .tick   (tick),
         .mode   (mode_e),
         .dim_on (dim_on),
         .led    (ledg[i])
      );
   end

endmodule

// File: tb/tb_led_activity.sv
// Directed bench for led_activity with a fast tick (PRESCALE=4,
// HOLD_TICKS=3, PWM_W=2); expected values are worked out by hand.
module tb_led_activity;

   localparam int NC = 8;
   localparam int PW = 2;

   logic          clock_160;
   logic          inp_resn;
   logic [NC-1:0] cog_act;
   logic [1:0]    mode;
   logic [PW-1:0] duty;
   logic [NC-1:0] ledg;

   int errors;
   int checks;
   int cnt;

   led_activity #(
      .NUMCOGS    (NC),
      .PRESCALE   (4),
      .HOLD_TICKS (3),
      .PWM_W      (PW)
   ) dut (
      .clock_160 (clock_160),
      .inp_resn  (inp_resn),
      .cog_act   (cog_act),
      .mode      (mode),
      .duty      (duty),
      .ledg      (ledg)
   );

   initial clock_160 = 1'b0;
   always #5 clock_160 = ~clock_160;

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock_160);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int got,
                          input int lo, input int hi);
      checks++;
      assert ((got >= lo) && (got <= hi)) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
      end
   endtask

   task automatic count_bit(input int idx, input int n, output int c);
      c = 0;
      for (int k = 0; k < n; k++) begin
         step(1);
         if (ledg[idx]) c++;
      end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      inp_resn = 1'b0;
      cog_act  = '0;
      mode     = 2'b00;
      duty     = '0;

      step(3);
      chk("reset_ledg", 32'(ledg), 32'h0);
      inp_resn = 1'b1;
      step(4);

      // direct mode latency
      cog_act = 8'h05;
      step(2);
      chk("direct_pre", 32'(ledg), 32'h00);
      step(1);
      chk("direct_on", 32'(ledg), 32'h05);
      cog_act = 8'h00;
      step(2);
      chk("direct_hold", 32'(ledg), 32'h05);
      step(1);
      chk("direct_off", 32'(ledg), 32'h00);

      // one-cycle pulse stretched to three ticks
      mode    = 2'b01;
      cog_act = 8'h01;
      step(1);
      cog_act = 8'h00;
      count_bit(0, 30, cnt);
      chk_rng("pulse_len", cnt, 8, 16);
      chk("pulse_end", 32'(ledg), 32'h00);

      // bit 2 held: continuous, then full stretch after release
      cog_act = 8'h04;
      step(3);
      count_bit(2, 20, cnt);
      chk("held_cont", 32'(cnt), 32'd20);
      cog_act = 8'h00;
      count_bit(2, 30, cnt);
      chk_rng("held_tail", cnt, 8, 16);

      // dimmed stretch, bit 1 held
      cog_act = 8'h02;
      mode    = 2'b10;
      duty    = 2'd1;
      step(4);
      count_bit(1, 64, cnt);
      chk("dim_d1", 32'(cnt), 32'd16);
      duty = 2'd2;
      step(2);
      count_bit(1, 64, cnt);
      chk("dim_d2", 32'(cnt), 32'd32);
      duty = 2'd3;
      step(2);
      count_bit(1, 64, cnt);
      chk("dim_d3", 32'(cnt), 32'd48);
      duty = 2'd0;
      step(2);
      count_bit(1, 64, cnt);
      chk("dim_d0", 32'(cnt), 32'd0);

      // lamp test and return to stretch
      mode = 2'b11;
      step(1);
      chk("lamp_on", 32'(ledg), 32'hFF);
      mode = 2'b01;
      step(1);
      chk("lamp_back", 32'(ledg), 32'h02);
      cog_act = 8'h00;
      step(3);
      mode = 2'b11;
      step(1);
      chk("lamp_mid", 32'(ledg), 32'hFF);
      mode = 2'b01;
      step(1);
      chk("lamp_keep", 32'(ledg), 32'h02);
      step(20);
      chk("lamp_decay", 32'(ledg), 32'h00);

      // reset in the middle of a stretch
      cog_act = 8'h01;
      step(1);
      cog_act = 8'h00;
      step(3);
      chk("rst_pre", 32'(ledg), 32'h01);
      inp_resn = 1'b0;
      #1;
      chk("rst_async", 32'(ledg), 32'h00);
      step(2);
      inp_resn = 1'b1;
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         step(1);
         if (ledg != '0) cnt++;
      end
      chk("rst_residual", 32'(cnt), 32'd0);
      mode    = 2'b00;
      cog_act = 8'h80;
      step(3);
      chk("rst_new_act", 32'(ledg), 32'h80);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
